hilo_mdu: RTL and testbench

Multiply/divide unit and HI/LO register pair in the E stage of the pipelined MIPS core. Consumes the `start` strobe and `hiloop` code that the instruction decoder issues for MULT/MULTU/DIV/DIVU/MTHI/MTLO. Runs the multi-cycle operation and reports `busy` to the hazard unit. Holds HI/LO for MFHI/MFLO.

---
 rtl/hilo_mdu_pkg.sv | 43 ++++
 rtl/hilo_mdu_arith.sv | 74 +++++++
 rtl/hilo_mdu.sv | 103 ++++++++++
 tb/tb_hilo_mdu.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_mdu_pkg.sv
// Shared HI/LO operation codes, default latencies and FSM state type for hilo_mdu.
// Optional macro MDU_MADD_EN adds the madd/maddu/msub/msubu accumulate codes.
package hilo_mdu_pkg;

    localparam int HILO_W = 11;

    localparam logic [HILO_W-1:0] HILO_MULT  = 11'd1;
    localparam logic [HILO_W-1:0] HILO_MULTU = 11'd2;
    localparam logic [HILO_W-1:0] HILO_DIV   = 11'd3;
    localparam logic [HILO_W-1:0] HILO_DIVU  = 11'd4;
    localparam logic [HILO_W-1:0] HILO_TOHI  = 11'd5;
    localparam logic [HILO_W-1:0] HILO_TOLO  = 11'd6;
    localparam logic [HILO_W-1:0] HILO_MADD  = 11'd7;
    localparam logic [HILO_W-1:0] HILO_MADDU = 11'd8;
    localparam logic [HILO_W-1:0] HILO_MSUB  = 11'd9;
    localparam logic [HILO_W-1:0] HILO_MSUBU = 11'd10;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } mdu_state_t;

    // Codes that launch a multi-cycle operation; accumulate codes only exist when enabled.
    function automatic logic is_arith_op(input logic [HILO_W-1:0] op);
        logic r;
        case (op)
            HILO_MULT, HILO_MULTU, HILO_DIV, HILO_DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
            HILO_MADD, HILO_MADDU, HILO_MSUB, HILO_MSUBU: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_div_op(input logic [HILO_W-1:0] op);
        return (op == HILO_DIV) || (op == HILO_DIVU);
    endfunction

endpackage

// File: rtl/hilo_mdu_arith.sv
// Combinational arithmetic for hilo_mdu: computes the next {HI,LO} pair and the divide-by-zero flag.
// Optional macro MDU_MADD_EN enables the accumulate (madd/msub family) datapath.
module mdu_arith
    import hilo_mdu_pkg::*;
(
    input  logic [HILO_W-1:0] op,
    input  logic [31:0]       A,
    input  logic [31:0]       B,
    input  logic [31:0]       HI,
    input  logic [31:0]       LO,
    output logic [31:0]       hi_q,
    output logic [31:0]       lo_q,
    output logic              div0
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] quo_m;
    logic [31:0] rem_m;
    logic [31:0] quo_u;
    logic [31:0] rem_u;

    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide works on magnitudes so -2^31 / -1 stays well defined.
    assign mag_a = A[31] ? (~A + 32'd1) : A;
    assign mag_b = B[31] ? (~B + 32'd1) : B;
    assign quo_m = mag_a / mag_b;
    assign rem_m = mag_a % mag_b;
    assign quo_u = A / B;
    assign rem_u = A % B;

`ifdef MDU_MADD_EN
    logic [63:0] acc;
    assign acc = {HI, LO};
`endif

    always_comb begin
        hi_q = HI;
        lo_q = LO;
        div0 = 1'b0;
        case (op)
            HILO_MULT:  {hi_q, lo_q} = prod_s;
            HILO_MULTU: {hi_q, lo_q} = prod_u;
            HILO_DIV: begin
                if (B == 32'd0) begin
                    div0 = 1'b1;
                end else begin
                    lo_q = (A[31] ^ B[31]) ? (~quo_m + 32'd1) : quo_m;
                    hi_q = A[31] ? (~rem_m + 32'd1) : rem_m;
                end
            end
            HILO_DIVU: begin
                if (B == 32'd0) begin
                    div0 = 1'b1;
                end else begin
                    lo_q = quo_u;
                    hi_q = rem_u;
                end
            end
`ifdef MDU_MADD_EN
            HILO_MADD:  {hi_q, lo_q} = acc + prod_s;
            HILO_MADDU: {hi_q, lo_q} = acc + prod_u;
            HILO_MSUB:  {hi_q, lo_q} = acc - prod_s;
            HILO_MSUBU: {hi_q, lo_q} = acc - prod_u;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/hilo_mdu.sv
// E-stage multiply/divide unit with the architectural HI/LO pair and a busy flag for the hazard unit.
// Optional macro MDU_MADD_EN (via hilo_mdu_pkg / mdu_arith) adds madd/maddu/msub/msubu.
module hilo_mdu
    import hilo_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [HILO_W-1:0] hiloop,
    input  logic [31:0]       A,
    input  logic [31:0]       B,
    output logic              busy,
    output logic [31:0]       HI,
    output logic [31:0]       LO
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;

    mdu_state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [31:0] hi_q, hi_q_nxt, lo_q, lo_q_nxt;
    logic [31:0] hi_r, hi_r_nxt, lo_r, lo_r_nxt;
    logic        div0, div0_nxt;
    logic [31:0] a_hi, a_lo;
    logic        a_div0;

    mdu_arith u_arith (
        .op   (hiloop),
        .A    (A),
        .B    (B),
        .HI   (hi_r),
        .LO   (lo_r),
        .hi_q (a_hi),
        .lo_q (a_lo),
        .div0 (a_div0)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            div0  <= 1'b0;
            hi_r  <= '0;
            lo_r  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            hi_q  <= hi_q_nxt;
            lo_q  <= lo_q_nxt;
            div0  <= div0_nxt;
            hi_r  <= hi_r_nxt;
            lo_r  <= lo_r_nxt;
        end
    end

    // Requests arriving while RUN are dropped; the hazard unit holds them in D.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hi_q_nxt  = hi_q;
        lo_q_nxt  = lo_q;
        div0_nxt  = div0;
        hi_r_nxt  = hi_r;
        lo_r_nxt  = lo_r;
        case (state)
            ST_IDLE: begin
                if (start && is_arith_op(hiloop)) begin
                    hi_q_nxt  = a_hi;
                    lo_q_nxt  = a_lo;
                    div0_nxt  = a_div0;
                    cnt_nxt   = is_div_op(hiloop) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    state_nxt = ST_RUN;
                end else if (hiloop == HILO_TOHI) begin
                    hi_r_nxt = A;
                end else if (hiloop == HILO_TOLO) begin
                    lo_r_nxt = A;
                end
            end
            ST_RUN: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = ST_IDLE;
                    if (!div0) begin
                        hi_r_nxt = hi_q;
                        lo_r_nxt = lo_q;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_RUN);
    assign HI   = hi_r;
    assign LO   = lo_r;

endmodule

// File: tb/tb_hilo_mdu.sv
// Self-checking bench for hilo_mdu: directed cases plus randomized operations against a 64-bit arithmetic model.
// Honours MDU_MADD_EN the same way as the design build.
module tb_hilo_mdu;

    localparam logic [10:0] OP_NONE  = 11'd0;
    localparam logic [10:0] OP_MULT  = 11'd1;
    localparam logic [10:0] OP_MULTU = 11'd2;
    localparam logic [10:0] OP_DIV   = 11'd3;
    localparam logic [10:0] OP_DIVU  = 11'd4;
    localparam logic [10:0] OP_TOHI  = 11'd5;
    localparam logic [10:0] OP_TOLO  = 11'd6;
    localparam logic [10:0] OP_MADD  = 11'd7;
    localparam logic [10:0] OP_MADDU = 11'd8;
    localparam logic [10:0] OP_MSUB  = 11'd9;
    localparam logic [10:0] OP_MSUBU = 11'd10;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] hiloop;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] HI, LO;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_hi, model_lo;

    hilo_mdu dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .hiloop (hiloop),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .HI     (HI),
        .LO     (LO)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Behavioural reference: new {HI,LO} and busy latency (0 = no multi-cycle op).
    function automatic void refModel(input logic [10:0] op, input logic s, input logic [31:0] a,
                                     input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                                     output logic [31:0] nhi, output logic [31:0] nlo, output int lat);
        longint sa, sb, q, r;
        longint unsigned ua, ub, acc;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        acc = {hi, lo};
        nhi = hi;
        nlo = lo;
        lat = 0;
        case (op)
            OP_MULT:  if (s) begin {nhi, nlo} = sa * sb; lat = MULT_N; end
            OP_MULTU: if (s) begin {nhi, nlo} = ua * ub; lat = MULT_N; end
            OP_DIV: if (s) begin
                lat = DIV_N;
                if (b != 0) begin
                    q = sa / sb;
                    r = sa % sb;
                    nlo = q[31:0];
                    nhi = r[31:0];
                end
            end
            OP_DIVU: if (s) begin
                lat = DIV_N;
                if (b != 0) begin
                    nlo = a / b;
                    nhi = a % b;
                end
            end
            OP_TOHI: nhi = a;
            OP_TOLO: nlo = a;
`ifdef MDU_MADD_EN
            OP_MADD:  if (s) begin {nhi, nlo} = acc + (sa * sb); lat = MULT_N; end
            OP_MADDU: if (s) begin {nhi, nlo} = acc + (ua * ub); lat = MULT_N; end
            OP_MSUB:  if (s) begin {nhi, nlo} = acc - (sa * sb); lat = MULT_N; end
            OP_MSUBU: if (s) begin {nhi, nlo} = acc - (ua * ub); lat = MULT_N; end
`endif
            default: ;
        endcase
    endfunction

    // Called at a negedge; returns at the following negedge with inputs idle.
    task automatic applyStimulus(input logic s, input logic [10:0] op, input logic [31:0] a, input logic [31:0] b);
        start  = s;
        hiloop = op;
        A      = a;
        B      = b;
        @(negedge clk);
        start  = 1'b0;
        hiloop = OP_NONE;
        A      = $urandom;
        B      = $urandom;
    endtask

    task automatic runOp(input string tag, input logic [10:0] op, input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] nhi, nlo;
        int lat;
        refModel(op, s, a, b, model_hi, model_lo, nhi, nlo, lat);
        applyStimulus(s, op, a, b);
        for (int i = 0; i < lat; i++) begin
            checkOutput({tag, " busy"}, {31'd0, busy}, 32'd1);
            checkOutput({tag, " HI hold"}, HI, model_hi);
            checkOutput({tag, " LO hold"}, LO, model_lo);
            @(negedge clk);
        end
        checkOutput({tag, " busy done"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, " HI"}, HI, nhi);
        checkOutput({tag, " LO"}, LO, nlo);
        model_hi = nhi;
        model_lo = nlo;
    endtask

    initial begin
        logic [31:0] nhi, nlo;
        logic [10:0] op;
        logic s;
        int lat;
        logic [10:0] pool [14] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_TOHI, OP_TOLO, OP_MADD,
                                   OP_MADDU, OP_MSUB, OP_MSUBU, OP_NONE, 11'd11, 11'd1024, OP_DIV};

        reset = 1'b1; start = 1'b0; hiloop = OP_NONE; A = '0; B = '0;
        model_hi = '0; model_lo = '0;
        #2;
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset HI", HI, 32'd0);
        checkOutput("reset LO", LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        runOp("mult", OP_MULT, 1'b1, 32'hFFFFFFFF, 32'd2);
        checkOutput("mult HI const", HI, 32'hFFFFFFFF);
        checkOutput("mult LO const", LO, 32'hFFFFFFFE);
        runOp("multu", OP_MULTU, 1'b1, 32'hFFFFFFFF, 32'd2);
        checkOutput("multu HI const", HI, 32'h00000001);
        runOp("div", OP_DIV, 1'b1, 32'hFFFFFFF9, 32'd2);
        checkOutput("div LO const", LO, 32'hFFFFFFFD);
        checkOutput("div HI const", HI, 32'hFFFFFFFF);
        runOp("divu", OP_DIVU, 1'b1, 32'd7, 32'd2);
        checkOutput("divu LO const", LO, 32'd3);
        checkOutput("divu HI const", HI, 32'd1);
        runOp("mthi preset", OP_TOHI, 1'b0, 32'hAAAA0000, 32'd0);
        runOp("mtlo preset", OP_TOLO, 1'b1, 32'h00005555, 32'd0);
        runOp("div0", OP_DIV, 1'b1, 32'd123, 32'd0);
        checkOutput("div0 HI const", HI, 32'hAAAA0000);
        checkOutput("div0 LO const", LO, 32'h00005555);
        runOp("mthi", OP_TOHI, 1'b0, 32'h12345678, 32'd0);
        checkOutput("mthi HI const", HI, 32'h12345678);
        runOp("divmin", OP_DIV, 1'b1, 32'h80000000, 32'hFFFFFFFF);

        runOp("madd HI0", OP_TOHI, 1'b0, 32'd0, 32'd0);
        runOp("madd LO5", OP_TOLO, 1'b0, 32'd5, 32'd0);
        runOp("madd", OP_MADD, 1'b1, 32'd3, 32'd4);
`ifdef MDU_MADD_EN
        checkOutput("madd LO const", LO, 32'd17);
`else
        checkOutput("madd LO const", LO, 32'd5);
`endif
        checkOutput("madd HI const", HI, 32'd0);

        for (int n = 0; n < 40; n++) begin
            op = pool[$urandom_range(0, 13)];
            s  = ((op >= OP_MULT && op <= OP_DIVU) || (op >= OP_MADD && op <= OP_MSUBU)) ? 1'b1 : 1'($urandom_range(0, 1));
            runOp($sformatf("rand%0d op%0d", n, op), op, s, $urandom,
                  ($urandom_range(0, 7) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 100))));
        end

        // Requests during an in-flight mult must be dropped, not queued.
        refModel(OP_MULT, 1'b1, 32'd1000, 32'd999, model_hi, model_lo, nhi, nlo, lat);
        applyStimulus(1'b1, OP_MULT, 32'd1000, 32'd999);
        for (int i = 0; i < MULT_N; i++) begin
            checkOutput("inflight busy", {31'd0, busy}, 32'd1);
            start = (i == 2); hiloop = (i == 1) ? OP_TOLO : ((i == 2) ? OP_DIVU : OP_NONE);
            A = 32'hDEAD0000; B = 32'd7;
            @(negedge clk);
        end
        start = 1'b0; hiloop = OP_NONE;
        checkOutput("inflight busy done", {31'd0, busy}, 32'd0);
        checkOutput("inflight HI", HI, nhi);
        checkOutput("inflight LO", LO, nlo);
        @(negedge clk);
        checkOutput("inflight no queue", {31'd0, busy}, 32'd0);
        checkOutput("inflight LO kept", LO, nlo);
        model_hi = nhi; model_lo = nlo;

        runOp("pre-reset mthi", OP_TOHI, 1'b0, 32'hCAFEF00D, 32'd0);
        applyStimulus(1'b1, OP_DIV, 32'd100, 32'd3);
        for (int i = 0; i < 3; i++) begin
            checkOutput("reset-op busy", {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        checkOutput("reset-op busy4", {31'd0, busy}, 32'd1);
        #1 reset = 1'b1;
        #1;
        checkOutput("async reset busy", {31'd0, busy}, 32'd0);
        checkOutput("async reset HI", HI, 32'd0);
        checkOutput("async reset LO", LO, 32'd0);
        model_hi = '0; model_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        runOp("post-reset mult", OP_MULT, 1'b1, 32'h00010001, 32'h00010001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
